busca_instrucao: RTL and testbench
==================================

Name: busca_instrucao

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC address, runs a req/ack transaction with instruction memory, and buffers returned words with their PCs in a small FIFO.
- Presents buffered instructions to decode over a valid/ready handshake.
- Pulses pc_avanca back to the PC on each accepted fetch. Supports flush on taken jal/branch.

Parameters:
- ADDR_W, 6, width of the instruction address bus (matches the PC's i_mem_addr width).
- FIFO_DEPTH, 2, number of buffered instruction entries (power of two, ≥2).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- pc_addr  in  ADDR_W  current PC value to fetch.
- pc_avanca  out  1  one-cycle pulse: pc_addr consumed, PC may advance.
- flush  in  1  discard all buffered and in-flight instructions (taken jal/branch).
- imem_req  out  1  request to instruction memory.
- imem_addr  out  ADDR_W  request address; stable while imem_req=1.
- imem_ack  in  1  memory completes transfer this cycle; imem_rdata valid.
- imem_rdata  in  32  instruction word from memory.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_ready  in  1  decode accepts head this cycle.
- inst  out  32  head instruction; 32'h00000013 (NOP) when empty.
- inst_pc  out  ADDR_W  PC of head instruction; 0 when empty.

Behaviour:
- Reset (sync, posedge clock with reset=1):
  - state=OCIOSO, count=0, head/tail pointers=0.
  - imem_req=0, imem_addr=0, pc_avanca=0.
  - inst_valid=0, inst=32'h00000013, inst_pc=0.
  - Reset has priority over every other input, including mid-transaction. The memory side must tolerate a dropped request.
- FSM states: OCIOSO, BUSCA, DESCARTE.
- OCIOSO:
  - If !flush and count < FIFO_DEPTH, go to BUSCA next cycle.
  - On entry to BUSCA: imem_req=1 and imem_addr=pc_addr, both registered.
- BUSCA:
  - imem_req is held at 1 and imem_addr held constant until imem_ack.
  - A transfer occurs when imem_req & imem_ack in the same cycle.
  - Ack without flush: push {imem_rdata, imem_addr} at tail; pc_avanca=1 this cycle (combinational: imem_req & imem_ack & !flush & state==BUSCA). Next state OCIOSO, imem_req=0.
  - Flush with ack in the same cycle: data dropped, no push, pc_avanca=0, next state OCIOSO.
  - Flush without ack: next state DESCARTE.
- DESCARTE:
  - imem_req stays 1 with the same address; a request is never withdrawn mid-handshake.
  - On imem_ack: data dropped, pc_avanca=0, next state OCIOSO.
  - A further flush while in DESCARTE has no additional effect.
- Flush on the FIFO side: count, head and tail are cleared at the next edge. Flush beats push and pop in the same cycle. inst_valid=0 in the cycle after flush.
- FIFO:
  - inst_valid = (count != 0); inst and inst_pc come combinationally from the head entry.
  - Pop when inst_valid & inst_ready & !flush.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push never occurs when full: a request is issued only when count < FIFO_DEPTH, and at most one request is outstanding.
  - inst_ready while empty is ignored.
- Latency and throughput:
  - With a zero-wait memory (ack in the first req cycle): pc_addr sampled in OCIOSO → imem_req at edge +1 → ack same cycle → inst_valid at edge +2.
  - Steady-state throughput: 1 instruction per 2 cycles (BUSCA/OCIOSO alternation), so the PC update lands before the next sample.
- Each ack in BUSCA without flush produces exactly one pc_avanca pulse. DESCARTE never produces one.

Test Plan:
- Reset, then pc_addr=0, zero-wait memory returning 32'h00500093 → imem_req at cycle 1 with addr 0, pc_avanca pulse at cycle 1, inst_valid=1 at cycle 2 with inst=32'h00500093, inst_pc=0.
- inst_ready=0 held, PC stepping 0,4,8 → exactly 2 fetches buffered (count=2), no third imem_req. Raise inst_ready → entries pop in order (pc 0, then 4), then fetch of 8 resumes.
- Memory with 3-cycle ack delay → imem_req and imem_addr stable for all 3 cycles, one pc_avanca pulse only in the ack cycle.
- Flush asserted during BUSCA 1 cycle before a delayed ack → FSM enters DESCARTE, acked word discarded, no pc_avanca, FIFO empty; next request uses the new pc_addr=0x20.
- Flush in the same cycle as ack, with inst_valid&inst_ready → no push, no pop effect, count=0 next cycle, inst=32'h00000013.
- Reset asserted mid-BUSCA with 1 entry buffered → next cycle imem_req=0, inst_valid=0, state OCIOSO. A late ack from the memory model is ignored.

Source files
------------

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: issues one req/ack read per PC value and buffers the
// returned words with their PCs in a small FIFO feeding decode.
module busca_instrucao #(
    parameter int ADDR_W     = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_avanca,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {OCIOSO, BUSCA, DESCARTE} estado_t;

    estado_t           state;
    estado_t           next_state;
    logic [ADDR_W-1:0] addr_reg;

    logic [31:0]       fifo_inst [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              has_room;
    logic              push;
    logic              pop;

    assign has_room = (count < CNT_W'(FIFO_DEPTH));

    // The request address is latched only on the OCIOSO->BUSCA transition so it
    // stays constant for the whole handshake, including any DESCARTE tail.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= OCIOSO;
            addr_reg <= '0;
        end else begin
            state <= next_state;
            if (state == OCIOSO && next_state == BUSCA) begin
                addr_reg <= pc_addr;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            OCIOSO: begin
                if (!flush && has_room) next_state = BUSCA;
            end
            BUSCA: begin
                if (imem_ack)   next_state = OCIOSO;
                else if (flush) next_state = DESCARTE;
            end
            DESCARTE: begin
                if (imem_ack) next_state = OCIOSO;
            end
            default: next_state = OCIOSO;
        endcase
    end

    always_comb begin
        imem_req  = (state != OCIOSO);
        imem_addr = addr_reg;
        pc_avanca = (state == BUSCA) && imem_req && imem_ack && !flush;
    end

    assign push = pc_avanca;
    assign pop  = inst_valid && inst_ready && !flush;

    // Flush wins over simultaneous push and pop.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_inst[tail] <= imem_rdata;
            fifo_pc[tail]   <= imem_addr;
        end
    end

    always_comb begin
        inst_valid = (count != '0);
        inst       = inst_valid ? fifo_inst[head] : NOP;
        inst_pc    = inst_valid ? fifo_pc[head]   : '0;
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: memory ack and PC values are driven by hand
// cycle by cycle, with expected outputs worked out for each step.
module tb_busca_instrucao;

    localparam int ADDR_W = 6;
    localparam logic [31:0] NOP = 32'h00000013;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_avanca;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;

    int total = 0;
    int bad   = 0;

    busca_instrucao #(.ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .pc_avanca  (pc_avanca),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        pc_addr    = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        inst_ready = 1'b0;
        step();
        step();
        // cycle 0: reset state
        chk("rst_req",   32'(imem_req),   32'd0);
        chk("rst_addr",  32'(imem_addr),  32'd0);
        chk("rst_avanca",32'(pc_avanca),  32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst",  inst,            NOP);
        chk("rst_pc",    32'(inst_pc),    32'd0);

        // zero-wait memory: ack held high
        reset      = 1'b0;
        pc_addr    = 6'd0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h00500093;
        step(); // cycle 1
        chk("zw_req",    32'(imem_req),  32'd1);
        chk("zw_addr",   32'(imem_addr), 32'd0);
        chk("zw_avanca", 32'(pc_avanca), 32'd1);
        pc_addr = 6'd4;
        step(); // cycle 2
        chk("zw_valid",  32'(inst_valid), 32'd1);
        chk("zw_inst",   inst,            32'h00500093);
        chk("zw_pc",     32'(inst_pc),    32'd0);
        chk("zw_req_lo", 32'(imem_req),   32'd0);

        // back-pressure: fill the FIFO
        imem_rdata = 32'h00100113;
        step(); // cycle 3
        chk("bp_req",    32'(imem_req),  32'd1);
        chk("bp_addr",   32'(imem_addr), 32'd4);
        chk("bp_avanca", 32'(pc_avanca), 32'd1);
        pc_addr = 6'd8;
        step(); // cycle 4
        chk("bp_req_lo4", 32'(imem_req), 32'd0);
        step(); // cycle 5
        chk("full_no_req", 32'(imem_req), 32'd0);
        chk("full_head",   32'(inst_pc),  32'd0);
        inst_ready = 1'b1;
        imem_rdata = 32'h00200193;
        step(); // cycle 6
        chk("pop1_pc",   32'(inst_pc), 32'd4);
        chk("pop1_inst", inst,         32'h00100113);
        chk("pop1_req",  32'(imem_req),32'd0);
        step(); // cycle 7
        inst_ready = 1'b0;
        chk("resume_req",    32'(imem_req),   32'd1);
        chk("resume_addr",   32'(imem_addr),  32'd8);
        chk("resume_avanca", 32'(pc_avanca),  32'd1);
        chk("drained_valid", 32'(inst_valid), 32'd0);
        chk("drained_inst",  inst,            NOP);
        step(); // cycle 8
        chk("wrap_pc",   32'(inst_pc), 32'd8);
        chk("wrap_inst", inst,         32'h00200193);

        // 3-cycle ack delay
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        pc_addr    = 6'h0C;
        step(); // cycle 9
        inst_ready = 1'b0;
        chk("dly1_req",    32'(imem_req),   32'd1);
        chk("dly1_addr",   32'(imem_addr),  32'h0C);
        chk("dly1_avanca", 32'(pc_avanca),  32'd0);
        chk("dly1_valid",  32'(inst_valid), 32'd0);
        step(); // cycle 10
        chk("dly2_req",    32'(imem_req),  32'd1);
        chk("dly2_addr",   32'(imem_addr), 32'h0C);
        chk("dly2_avanca", 32'(pc_avanca), 32'd0);
        step(); // cycle 11
        imem_ack   = 1'b1;
        imem_rdata = 32'h00300213;
        #1;
        chk("dly3_req",    32'(imem_req),  32'd1);
        chk("dly3_addr",   32'(imem_addr), 32'h0C);
        chk("dly3_avanca", 32'(pc_avanca), 32'd1);
        step(); // cycle 12
        imem_ack = 1'b0;
        pc_addr  = 6'h10;
        chk("dly_done_req",    32'(imem_req),   32'd0);
        chk("dly_done_avanca", 32'(pc_avanca),  32'd0);
        chk("dly_done_valid",  32'(inst_valid), 32'd1);
        chk("dly_done_pc",     32'(inst_pc),    32'h0C);
        chk("dly_done_inst",   inst,            32'h00300213);

        // flush one cycle before a delayed ack
        step(); // cycle 13
        chk("fl_req",  32'(imem_req),  32'd1);
        chk("fl_addr", 32'(imem_addr), 32'h10);
        flush   = 1'b1;
        pc_addr = 6'h20;
        step(); // cycle 14, DESCARTE
        flush      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        #1;
        chk("desc_req",    32'(imem_req),   32'd1);
        chk("desc_addr",   32'(imem_addr),  32'h10);
        chk("desc_avanca", 32'(pc_avanca),  32'd0);
        chk("desc_valid",  32'(inst_valid), 32'd0);
        step(); // cycle 15
        imem_ack = 1'b0;
        chk("desc_end_req",   32'(imem_req),   32'd0);
        chk("desc_end_valid", 32'(inst_valid), 32'd0);
        chk("desc_end_inst",  inst,            NOP);
        step(); // cycle 16
        chk("new_req",  32'(imem_req),  32'd1);
        chk("new_addr", 32'(imem_addr), 32'h20);

        // flush coincident with ack and with a pop
        imem_ack   = 1'b1;
        imem_rdata = 32'h00400293;
        #1;
        chk("b_avanca", 32'(pc_avanca), 32'd1);
        step(); // cycle 17
        imem_ack = 1'b0;
        pc_addr  = 6'h24;
        chk("b_valid", 32'(inst_valid), 32'd1);
        chk("b_pc",    32'(inst_pc),    32'h20);
        step(); // cycle 18
        imem_ack   = 1'b1;
        imem_rdata = 32'h00500313;
        flush      = 1'b1;
        inst_ready = 1'b1;
        #1;
        chk("fa_req",    32'(imem_req),  32'd1);
        chk("fa_addr",   32'(imem_addr), 32'h24);
        chk("fa_avanca", 32'(pc_avanca), 32'd0);
        step(); // cycle 19
        flush      = 1'b0;
        imem_ack   = 1'b0;
        inst_ready = 1'b0;
        chk("fa_valid", 32'(inst_valid), 32'd0);
        chk("fa_inst",  inst,            NOP);
        chk("fa_pc",    32'(inst_pc),    32'd0);
        chk("fa_req_lo",32'(imem_req),   32'd0);

        // reset in the middle of BUSCA with one entry buffered
        pc_addr = 6'h28;
        step(); // cycle 20
        imem_ack   = 1'b1;
        imem_rdata = 32'h00600393;
        step(); // cycle 21
        imem_ack = 1'b0;
        pc_addr  = 6'h2C;
        step(); // cycle 22
        chk("mr_req",   32'(imem_req),   32'd1);
        chk("mr_valid", 32'(inst_valid), 32'd1);
        chk("mr_pc",    32'(inst_pc),    32'h28);
        reset = 1'b1;
        step(); // cycle 23
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h00000BAD;
        #1;
        chk("mr_req_lo", 32'(imem_req),   32'd0);
        chk("mr_addr",   32'(imem_addr),  32'd0);
        chk("mr_vld_lo", 32'(inst_valid), 32'd0);
        chk("mr_inst",   inst,            NOP);
        chk("late_ack",  32'(pc_avanca),  32'd0);
        step(); // cycle 24
        imem_ack = 1'b0;
        #1;
        chk("late_valid", 32'(inst_valid), 32'd0);
        chk("late_req",   32'(imem_req),   32'd1);
        chk("late_addr",  32'(imem_addr),  32'h2C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
